// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect input, decode handshake and error flag.
// Decode handshake: an entry transfers on a rising edge where inst_valid && inst_ready; inst_valid/inst_data/inst_pc are registered and never depend on inst_ready.
interface fetch_unit_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  fetch_en;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0] imem_data;
   logic                  redirect_valid;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic                  inst_valid;
   logic [DATA_WIDTH-1:0] inst_data;
   logic [ADDR_WIDTH-1:0] inst_pc;
   logic                  inst_ready;
   logic                  misaligned_err;

   modport master (
      input  fetch_en, imem_data, redirect_valid, redirect_pc, inst_ready,
      output imem_addr, inst_valid, inst_data, inst_pc, misaligned_err
   );

   modport slave (
      output fetch_en, imem_data, redirect_valid, redirect_pc, inst_ready,
      input  imem_addr, inst_valid, inst_data, inst_pc, misaligned_err
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a combinational ROM and queues {pc, word}
// in a small prefetch FIFO for decode; redirects flush, misaligned redirects halt until reset.
module fetch_unit #(
   parameter int                ADDR_WIDTH = 32,
   parameter int                DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
   parameter int                FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   fetch_unit_if.master      io_bus,
   output logic [1:0]        o_dbg_state
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_fetch_pc, w_fetch_pc_nxt;
   logic [CW-1:0]         r_count, w_count_nxt;
   logic [PW-1:0]         r_rd_ptr, w_rd_ptr_nxt;
   logic [PW-1:0]         r_wr_ptr, w_wr_ptr_nxt;
   logic                  r_err, w_err_nxt;

   logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];

   logic w_pop, w_push, w_redirect, w_misalign, w_valid;

   assign w_valid    = (r_count != '0);
   assign w_pop      = w_valid && io_bus.inst_ready;
   assign w_redirect = io_bus.redirect_valid && (r_state != ST_ERROR);
   assign w_misalign = w_redirect && (io_bus.redirect_pc[1:0] != 2'b00);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push     = (r_state == ST_RUN) && !io_bus.redirect_valid &&
                       ((r_count != DEPTH_C) || w_pop);

   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      w_count_nxt    = r_count;
      w_rd_ptr_nxt   = r_rd_ptr;
      w_wr_ptr_nxt   = r_wr_ptr;
      w_err_nxt      = r_err;

      case (r_state)
         ST_IDLE:  if (io_bus.fetch_en)  w_state_nxt = ST_RUN;
         ST_RUN:   if (!io_bus.fetch_en) w_state_nxt = ST_IDLE;
         ST_ERROR: w_state_nxt = ST_ERROR;
         default:  w_state_nxt = ST_IDLE;
      endcase

      if (w_misalign) begin
         w_state_nxt  = ST_ERROR;
         w_err_nxt    = 1'b1;
         w_count_nxt  = '0;
         w_rd_ptr_nxt = '0;
         w_wr_ptr_nxt = '0;
      end else if (w_redirect) begin
         // Any pop this cycle is discarded along with the rest of the queue.
         w_count_nxt    = '0;
         w_rd_ptr_nxt   = '0;
         w_wr_ptr_nxt   = '0;
         w_fetch_pc_nxt = io_bus.redirect_pc;
      end else begin
         if (w_pop) w_rd_ptr_nxt = r_rd_ptr + 1'b1;
         if (w_push) begin
            w_wr_ptr_nxt   = r_wr_ptr + 1'b1;
            w_fetch_pc_nxt = r_fetch_pc + ADDR_WIDTH'(4);
         end
         case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_fetch_pc <= RESET_PC;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         r_count    <= w_count_nxt;
         r_rd_ptr   <= w_rd_ptr_nxt;
         r_wr_ptr   <= w_wr_ptr_nxt;
         r_err      <= w_err_nxt;
      end
   end

   // Storage needs no reset: the count decides what is visible.
   always_ff @(posedge clk) begin
      if (rst_n && w_push) begin
         r_fifo_data[r_wr_ptr] <= io_bus.imem_data;
         r_fifo_pc[r_wr_ptr]   <= r_fetch_pc;
      end
   end

   assign io_bus.imem_addr      = r_fetch_pc;
   assign io_bus.inst_valid     = w_valid;
   assign io_bus.inst_data      = w_valid ? r_fifo_data[r_rd_ptr] : '0;
   assign io_bus.inst_pc        = w_valid ? r_fifo_pc[r_rd_ptr]   : '0;
   assign io_bus.misaligned_err = r_err;
   assign o_dbg_state           = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, all checked every cycle
// against a queue-based model of the fetch stream.
module tb_fetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RST_PC   = 32'h0000_0000;
   localparam logic [31:0] RST_PC2  = 32'hFFFF_FFFC;

   logic clk;
   logic rst_n;
   logic [1:0] dbg_state;
   logic [1:0] dbg_state2;

   fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
   fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

   fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .io_bus(bus), .o_dbg_state(dbg_state)
   );

   fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(RST_PC2), .FIFO_DEPTH(DEPTH)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .io_bus(bus2), .o_dbg_state(dbg_state2)
   );

   // ROM contents: 0x00000013, 0x00100093, ... one distinct word per address.
   function automatic logic [31:0] rom_word(input logic [31:0] addr);
      return 32'h0000_0013 + (addr >> 2) * 32'h0010_0080;
   endfunction

   assign bus.imem_data       = rom_word(bus.imem_addr);
   assign bus2.imem_data      = rom_word(bus2.imem_addr);
   assign bus2.fetch_en       = 1'b1;
   assign bus2.inst_ready     = 1'b1;
   assign bus2.redirect_valid = 1'b0;
   assign bus2.redirect_pc    = 32'h0;

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard / model state
   logic [63:0] exp_q[$];
   logic [31:0] m_pc;
   bit          m_run;
   bit          m_err;
   int          n_checks;
   int          n_pass;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // One clock of the fetch stream, in terms of what decode should eventually see.
   task automatic model_update(input logic fen, input logic rv, input logic [31:0] rpc,
                               input logic rdy, input logic rstn);
      if (!rstn) begin
         m_pc = RST_PC; exp_q.delete(); m_run = 0; m_err = 0;
         return;
      end
      if (m_err) return;
      if (rv && rpc[1:0] != 2'b00) begin
         m_err = 1; exp_q.delete();
         return;
      end
      if (rv) begin
         exp_q.delete(); m_pc = rpc; m_run = fen;
         return;
      end
      if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
      if (m_run && exp_q.size() < DEPTH) begin
         exp_q.push_back({m_pc, rom_word(m_pc)});
         m_pc = m_pc + 32'd4;
      end
      m_run = fen;
   endtask

   task automatic compare_all();
      logic [63:0] head;
      head = (exp_q.size() != 0) ? exp_q[0] : 64'h0;
      chk("inst_valid", 64'(bus.inst_valid), 64'(exp_q.size() != 0));
      chk("inst_pc", 64'(bus.inst_pc), 64'(head[63:32]));
      chk("inst_data", 64'(bus.inst_data), 64'(head[31:0]));
      chk("imem_addr", 64'(bus.imem_addr), 64'(m_pc));
      chk("misaligned_err", 64'(bus.misaligned_err), 64'(m_err));
   endtask

   // driver: apply inputs, advance the model, clock, then check away from the edge
   task automatic step(input logic fen, input logic rv, input logic [31:0] rpc,
                       input logic rdy, input logic rstn);
      bus.fetch_en       = fen;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.inst_ready     = rdy;
      rst_n              = rstn;
      model_update(fen, rv, rpc, rdy, rstn);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      logic        fen, rv, rdy, rstn;
      logic [31:0] rpc;
      n_checks = 0;
      n_pass   = 0;
      m_pc = RST_PC; m_run = 0; m_err = 0;
      bus.fetch_en = 0; bus.redirect_valid = 0; bus.redirect_pc = 0; bus.inst_ready = 0;
      rst_n = 0;

      // streaming with decode always ready; wrap-around instance runs alongside
      do_reset();
      chk("rst_valid", 64'(bus.inst_valid), 64'(0));
      chk("rst_addr", 64'(bus.imem_addr), 64'(RST_PC));
      step(1, 0, 0, 1, 1);
      chk("lat_cycle1_valid", 64'(bus.inst_valid), 64'(0));
      step(1, 0, 0, 1, 1);
      chk("lat_cycle2_valid", 64'(bus.inst_valid), 64'(1));
      chk("lat_cycle2_pc", 64'(bus.inst_pc), 64'(32'h0));
      chk("lat_cycle2_data", 64'(bus.inst_data), 64'(32'h0000_0013));
      chk("wrap_pc0", 64'(bus2.inst_pc), 64'(32'hFFFF_FFFC));
      step(1, 0, 0, 1, 1);
      chk("stream_pc1", 64'(bus.inst_pc), 64'(32'h4));
      chk("stream_data1", 64'(bus.inst_data), 64'(32'h0010_0093));
      chk("wrap_pc1", 64'(bus2.inst_pc), 64'(32'h0));
      chk("wrap_valid1", 64'(bus2.inst_valid), 64'(1));
      step(1, 0, 0, 1, 1);
      chk("stream_pc2", 64'(bus.inst_pc), 64'(32'h8));

      // back-pressure fills the FIFO, then drain
      do_reset();
      for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 1);
      chk("full_addr_hold", 64'(bus.imem_addr), 64'(32'h10));
      for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 1);

      // redirect while full with a simultaneous pop
      do_reset();
      for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1);
      step(1, 1, 32'h40, 1, 1);
      chk("redir_valid", 64'(bus.inst_valid), 64'(0));
      chk("redir_addr", 64'(bus.imem_addr), 64'(32'h40));
      step(1, 0, 0, 1, 1);
      chk("redir_first_pc", 64'(bus.inst_pc), 64'(32'h40));
      step(1, 0, 0, 1, 1);

      // misaligned redirect halts until reset
      step(1, 1, 32'h42, 1, 1);
      chk("mis_err", 64'(bus.misaligned_err), 64'(1));
      chk("mis_valid", 64'(bus.inst_valid), 64'(0));
      for (int i = 0; i < 10; i++) step(1, (i % 3) == 0, 32'h80, 1, 1);
      chk("mis_still_empty", 64'(bus.inst_valid), 64'(0));
      do_reset();
      chk("mis_cleared", 64'(bus.misaligned_err), 64'(0));
      step(1, 0, 0, 1, 1);
      step(1, 0, 0, 1, 1);
      chk("mis_restart_pc", 64'(bus.inst_pc), 64'(RST_PC));

      // reset mid-stream with three entries queued
      do_reset();
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0);
      chk("midrst_valid", 64'(bus.inst_valid), 64'(0));
      chk("midrst_addr", 64'(bus.imem_addr), 64'(RST_PC));
      step(1, 0, 0, 1, 1);
      step(1, 0, 0, 1, 1);
      chk("midrst_first_pc", 64'(bus.inst_pc), 64'(RST_PC));

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         fen  = ($urandom_range(0, 9) != 0);
         rv   = ($urandom_range(0, 15) == 0);
         rpc  = $urandom() & 32'hFFFF_FFFC;
         if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF4;
         if ($urandom_range(0, 9) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
         rdy  = ($urandom_range(0, 3) != 0);
         rstn = ($urandom_range(0, 149) != 0);
         step(fen, rv, rpc, rdy, rstn);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
